// File: rtl/dac_load_sequencer.sv
// dac_load_sequencer
//
// Turns a thermometer code into the serial datum/shift/transfer/dir pin sequence of the
// CHAIN_LEN-source current-steering DAC shift chain. The analog output changes once per
// accepted code, on the single LOAD (chain->state) transfer.
//
// Optional feature: define PUDDING_DAC_READBACK_EN to add a CAPTURE/VERIFY readback phase.
// That phase copies state back into the chain and recirculates the pattern, comparing the
// chain MSB against the target.
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset (shared with the DAC chain)
//   code_i         requested number of active sources; saturates to CHAIN_LEN
//   code_valid_i   code_i valid; accepted when code_ready_o is high
//   code_ready_o   sequencer idle
//   chain_msb_i    daisychain[CHAIN_LEN-1] from the DAC (readback only)
//   datum_o        serial chain data
//   shift_o        chain shift enable
//   transfer_o     chain/state transfer strobe
//   dir_o          1 = chain->state, 0 = state->chain
//   busy_o         sequence in progress
//   done_o         one-cycle pulse in the first idle cycle after a sequence
//   loaded_code_o  code currently held in the DAC state register
//   verify_err_o   sticky readback mismatch flag (0 without readback)
module dac_load_sequencer #(
  parameter int unsigned CHAIN_LEN = 128,
  parameter int unsigned CODE_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_valid_i,
  output logic              code_ready_o,
  input  logic              chain_msb_i,
  output logic              datum_o,
  output logic              shift_o,
  output logic              transfer_o,
  output logic              dir_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CODE_W-1:0] loaded_code_o,
  output logic              verify_err_o
);

  localparam logic [CODE_W:0]   ChainLenW = (CODE_W + 1)'(CHAIN_LEN);
  localparam logic [CODE_W-1:0] ChainLenN = CODE_W'(CHAIN_LEN);
  localparam logic [CODE_W-1:0] LastK     = CODE_W'(CHAIN_LEN - 1);

`ifdef PUDDING_DAC_READBACK_EN
  typedef enum logic [2:0] {StIdle, StShift, StLoad, StCapture, StVerify} state_e;
`else
  typedef enum logic [2:0] {StIdle, StShift, StLoad} state_e;
`endif

  // Sequence bit k lands in state[CHAIN_LEN-1-k], so the top n sequence bits are ones.
  function automatic logic pattern(input logic [CODE_W-1:0] k, input logic [CODE_W-1:0] n);
    return {1'b0, k} >= (ChainLenW - {1'b0, n});
  endfunction

  state_e            state_q, state_d;
  logic [CODE_W-1:0] k_q, k_d, k_inc;
  logic [CODE_W-1:0] n_q, n_d, code_sat;
  logic [CODE_W-1:0] loaded_q, loaded_d;
  logic              ready_q, ready_d;
  logic              datum_q, datum_d;
  logic              shift_q, shift_d;
  logic              transfer_q, transfer_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef PUDDING_DAC_READBACK_EN
  logic              err_q, err_d;
`else
  logic              unused_chain_msb;
  assign unused_chain_msb = chain_msb_i;
`endif

  assign k_inc    = k_q + 1'b1;
  assign code_sat = ({1'b0, code_i} > ChainLenW) ? ChainLenN : code_i;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    loaded_d   = loaded_q;
    ready_d    = 1'b0;
    datum_d    = 1'b0;
    shift_d    = 1'b0;
    transfer_d = 1'b0;
    dir_d      = 1'b1;
    busy_d     = 1'b1;
    done_d     = 1'b0;
`ifdef PUDDING_DAC_READBACK_EN
    err_d      = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (code_valid_i && ready_q) begin
          n_d     = code_sat;
          k_d     = '0;
          state_d = StShift;
          shift_d = 1'b1;
          datum_d = pattern('0, code_sat);
`ifdef PUDDING_DAC_READBACK_EN
          err_d   = 1'b0;
`endif
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      StShift: begin
        if (k_q == LastK) begin
          state_d    = StLoad;
          transfer_d = 1'b1;
          dir_d      = 1'b1;
          loaded_d   = n_q;
        end else begin
          k_d     = k_inc;
          shift_d = 1'b1;
          datum_d = pattern(k_inc, n_q);
        end
      end
`ifdef PUDDING_DAC_READBACK_EN
      StLoad: begin
        state_d    = StCapture;
        transfer_d = 1'b1;
        dir_d      = 1'b0;
        k_d        = '0;
      end
      StCapture: begin
        state_d = StVerify;
        shift_d = 1'b1;
        datum_d = pattern('0, n_q);
      end
      StVerify: begin
        // Chain MSB before this shift edge holds sequence bit k.
        if (chain_msb_i != pattern(k_q, n_q)) begin
          err_d = 1'b1;
        end
        if (k_q == LastK) begin
          state_d = StIdle;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          k_d     = k_inc;
          shift_d = 1'b1;
          datum_d = pattern(k_inc, n_q);
        end
      end
`else
      StLoad: begin
        state_d = StIdle;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      n_q        <= '0;
      loaded_q   <= '0;
      ready_q    <= 1'b1;
      datum_q    <= 1'b0;
      shift_q    <= 1'b0;
      transfer_q <= 1'b0;
      dir_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PUDDING_DAC_READBACK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      loaded_q   <= loaded_d;
      ready_q    <= ready_d;
      datum_q    <= datum_d;
      shift_q    <= shift_d;
      transfer_q <= transfer_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PUDDING_DAC_READBACK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign code_ready_o  = ready_q;
  assign datum_o       = datum_q;
  assign shift_o       = shift_q;
  assign transfer_o    = transfer_q;
  assign dir_o         = dir_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign loaded_code_o = loaded_q;
`ifdef PUDDING_DAC_READBACK_EN
  assign verify_err_o  = err_q;
`else
  assign verify_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_dac_load_sequencer.sv
// Scoreboard bench for dac_load_sequencer: DAC chain/state model, ready/done timing model,
// per-transaction checks of the loaded DAC state, datum/shift counts and verify flag.
`timescale 1ns/1ps
module tb_dac_load_sequencer;

  localparam int L     = 128;
  localparam int CW    = 8;
  localparam int STUCK = 60;
`ifdef PUDDING_DAC_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int LAT    = RB ? 2 * L + 3 : L + 2;
  localparam int PASSES = RB ? 2 : 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] code_i;
  logic          code_valid_i;
  logic          code_ready_o, chain_msb_i, datum_o, shift_o, transfer_o, dir_o;
  logic          busy_o, done_o, verify_err_o;
  logic [CW-1:0] loaded_code_o;

  dac_load_sequencer #(.CHAIN_LEN(L), .CODE_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .code_ready_o (code_ready_o),
    .chain_msb_i  (chain_msb_i),
    .datum_o      (datum_o),
    .shift_o      (shift_o),
    .transfer_o   (transfer_o),
    .dir_o        (dir_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .loaded_code_o(loaded_code_o),
    .verify_err_o (verify_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int idle_cyc = 0;   // first cycle in which the model expects the DUT idle again
  int acc_count = 0;
  bit started = 1'b0;
  bit stuck = 1'b0;

  typedef struct {int n; int acc; bit stuck;} txn_t;
  txn_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Target DAC state; a stuck-at-1 chain flop corrupts every bit shifted through it.
  function automatic logic [L-1:0] exp_state(input int n, input bit st);
    logic [L-1:0] v;
    for (int i = 0; i < L; i++) v[i] = (i < n) || (st && i >= STUCK);
    return v;
  endfunction

  // DAC chain/state model, cleared by the shared reset.
  logic [L-1:0] chain, dac_state;
  assign chain_msb_i = chain[L-1];

  function automatic logic [L-1:0] chain_next(input logic [L-1:0] c, input logic [L-1:0] s,
                                              input logic sh, input logic d, input logic tr,
                                              input logic dr, input bit st);
    logic [L-1:0] v;
    v = c;
    if (sh) v = {c[L-2:0], d};
    if (tr && !dr) v = s;
    if (st) v[STUCK] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      chain     <= '0;
      dac_state <= '0;
    end else begin
      chain <= chain_next(chain, dac_state, shift_o, datum_o, transfer_o, dir_o, stuck);
      if (transfer_o && dir_o) dac_state <= chain;
    end
  end

  // Reference timing model and scoreboard producer.
  always @(negedge clk) begin
    if (started) begin
      chk("code_ready", code_ready_o, cyc >= idle_cyc);
      chk("busy", busy_o, cyc < idle_cyc);
    end
    if (!rst_n) begin
      sb.delete();
      idle_cyc = 0;
    end else if (code_valid_i && cyc >= idle_cyc) begin
      txn_t t;
      t.n   = (int'(code_i) > L) ? L : int'(code_i);
      t.acc = cyc;
      t.stuck = stuck;
      sb.push_back(t);
      idle_cyc = cyc + LAT;
      acc_count++;
    end
  end

  // Monitor: consumes scoreboard entries when done_o is due or seen.
  int shifts = 0, ones = 0, transfers = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      shifts = 0;
      ones = 0;
      transfers = 0;
    end else if (started) begin
      bit exp_done;
      chk("shift_xor_transfer", shift_o && transfer_o, 1'b0);
      if (shift_o) begin
        shifts++;
        if (datum_o) ones++;
      end
      if (transfer_o) transfers++;
      exp_done = (sb.size() > 0) && (cyc == sb[0].acc + LAT);
      chk("done_timing", done_o, exp_done);
      if (done_o || exp_done) begin
        if (sb.size() > 0) begin
          txn_t t;
          logic [L-1:0] es;
          t = sb.pop_front();
          es = exp_state(t.n, t.stuck);
          chk("loaded_code", loaded_code_o, t.n);
          chk_vec("dac_state", dac_state, es);
          chk("shift_count", shifts, L * PASSES);
          chk("datum_ones", ones, t.n * PASSES);
          chk("transfer_count", transfers, PASSES);
          chk("verify_err", verify_err_o, RB && (es != exp_state(t.n, 1'b0)));
        end
        shifts = 0;
        ones = 0;
        transfers = 0;
      end
    end
  end

  // Driver helpers: always entered and left at posedge + #1.
  task automatic wait_idle();
    int g = 0;
    while (cyc < idle_cyc && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle timeout: got busy expected idle");
    end
  endtask

  task automatic send(input int code, output int acc);
    wait_idle();
    acc = cyc;
    code_valid_i = 1'b1;
    code_i = CW'(code);
    @(posedge clk); #1;
    code_valid_i = 1'b0;
    code_i = CW'($urandom);
  endtask

  task automatic check_reset();
    chk("rst_ready", code_ready_o, 1'b1);
    chk("rst_datum", datum_o, 1'b0);
    chk("rst_shift", shift_o, 1'b0);
    chk("rst_transfer", transfer_o, 1'b0);
    chk("rst_dir", dir_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_loaded", loaded_code_o, 0);
    chk("rst_verify_err", verify_err_o, 1'b0);
    chk_vec("rst_dac_state", dac_state, '0);
  endtask

  initial begin
    int a, a0, g;
    rst_n = 1'b0;
    code_valid_i = 1'b0;
    code_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    started = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(5, a);
    send(200, a);
    send(128, a);
    send(0, a);

    // Back-to-back: valid held, code 20 appears only once idle; garbage while busy.
    wait_idle();
    a0 = acc_count;
    code_valid_i = 1'b1;
    code_i = 10;
    g = 0;
    while (acc_count < a0 + 2 && g < 1000) begin
      @(posedge clk); #1;
      g++;
      if (acc_count == a0) code_i = 10;
      else code_i = (cyc >= idle_cyc) ? CW'(20) : CW'($urandom);
    end
    code_valid_i = 1'b0;
    chk("b2b_accepts", acc_count - a0, 2);

`ifdef PUDDING_DAC_READBACK_EN
    stuck = 1'b1;
    send(3, a);
    send(128, a);
    @(posedge clk); #1;
    wait_idle();
    stuck = 1'b0;
`endif

    // Reset during SHIFT cycle 64 of code 100.
    send(100, a);
    while (cyc < a + 64) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    send(77, a);

    // Random traffic with boundary-biased codes.
    for (int i = 0; i < 2500; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      code_valid_i = ($urandom_range(0, 3) == 0);
      case (sel)
        0: code_i = 0;
        1: code_i = CW'(L - 1);
        2: code_i = CW'(L);
        3: code_i = CW'(L + 1);
        4: code_i = '1;
        default: code_i = CW'($urandom);
      endcase
      @(posedge clk); #1;
    end
    code_valid_i = 1'b0;

    g = 0;
    while (sb.size() > 0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
